universal_shift_register: RTL

- Parametrised successor to the fixed 4-bit serial-in/serial-out shift register.
- WIDTH-bit universal register with four modes: hold, shift right, shift left and parallel load.
- Provides serial in/out at both ends, a parallel output, and a shift counter that pulses word_done after every WIDTH shifts.
- Used as a serialiser/deserialiser stage between parallel datapaths and single-wire links in lab designs.

---
 rtl/universal_shift_register.sv | 99 +++++++++
 1 files changed

// File: rtl/universal_shift_register.sv
// universal_shift_register
//   WIDTH-bit universal shift register: hold, shift right, shift left and
//   parallel load, with serial taps at both ends and a shift counter that
//   pulses word_done once every WIDTH shifts.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset (q=RESET_VALUE, count=0)
//   en            clock enable; 0 holds q and shift_count, clears word_done
//   mode          00 hold, 01 shift right, 10 shift left, 11 parallel load
//   serial_in_r   bit entering the MSB on a right shift
//   serial_in_l   bit entering the LSB on a left shift
//   parallel_in   word captured on parallel load
//   parallel_out  register contents q
//   serial_out_r  q[0]
//   serial_out_l  q[WIDTH-1]
//   shift_count   shifts since last load/reset/wrap, 0..WIDTH-1
//   word_done     registered one-cycle pulse after every WIDTH-th shift
module universal_shift_register #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic                     serial_in_r,
    input  logic                     serial_in_l,
    input  logic [WIDTH-1:0]         parallel_in,
    output logic [WIDTH-1:0]         parallel_out,
    output logic                     serial_out_r,
    output logic                     serial_out_l,
    output logic [$clog2(WIDTH)-1:0] shift_count,
    output logic                     word_done
);

    localparam int unsigned   CW         = $clog2(WIDTH);
    // Explicit wrap point: natural overflow is only correct for power-of-two WIDTH.
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        MODE_HOLD    = 2'b00,
        MODE_SHIFT_R = 2'b01,
        MODE_SHIFT_L = 2'b10,
        MODE_LOAD    = 2'b11
    } mode_t;

    mode_t            op;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    count;
    logic             done;
    logic             is_shift;

    assign op       = mode_t'(mode);
    assign is_shift = en && ((op == MODE_SHIFT_R) || (op == MODE_SHIFT_L));

    // Data path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (en) begin
            case (op)
                MODE_HOLD:    q <= q;
                MODE_SHIFT_R: q <= {serial_in_r, q[WIDTH-1:1]};
                MODE_SHIFT_L: q <= {q[WIDTH-2:0], serial_in_l};
                MODE_LOAD:    q <= parallel_in;
                default:      q <= q;
            endcase
        end
    end

    // Shift counter and word-complete pulse; both directions count alike,
    // and a load abandons the word in progress without a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (en && (op == MODE_LOAD)) begin
                count <= '0;
            end else if (is_shift) begin
                if (count == LAST_COUNT) begin
                    count <= '0;
                    done  <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

    assign parallel_out = q;
    assign serial_out_r = q[0];
    assign serial_out_l = q[WIDTH-1];
    assign shift_count  = count;
    assign word_done    = done;

endmodule
